dcache_sa2_wb: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the MEM stage of the 5-stage RISC-V pipeline and the word-addressed data memory (D_MEM_* interface).
- Generalises the fixed single-configuration cache: set count, line length, memory latency and address width are configurable; adds LRU replacement, dirty-line writeback and hit/miss performance counters.
- The pipeline freezes via `stall` while a miss is serviced.

---
 rtl/dcache_sa2_wb.sv | 240 ++++++++++++++++++++++++
 tb/tb_dcache_sa2_wb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sa2_wb.sv
// Two-way set-associative, write-back, write-allocate data cache.
// It sits between the MEM pipeline stage and a word-addressed data memory.
// Ports:
//   CLK, RSTn                    clock; synchronous active-low reset
//   req_valid/we/addr/be/wdata   MEM-stage access request (held while stall=1)
//   req_rdata                    load data (combinational on hit / RESPOND)
//   stall                        pipeline freeze while a miss is serviced
//   mem_csn/wen/addr/be/dout     data-memory request (csn/wen active-low)
//   mem_din                      data-memory read data
//   hit_count, miss_count        performance counters (wrap modulo 2^32)
module dcache_sa2_wb #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned NUM_SETS       = 4,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned MEM_LATENCY    = 2
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [3:0]          req_be,
    input  logic [31:0]         req_wdata,
    output logic [31:0]         req_rdata,
    output logic                stall,
    output logic                mem_csn,
    output logic                mem_wen,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [3:0]          mem_be,
    output logic [31:0]         mem_dout,
    input  logic [31:0]         mem_din,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Storage: tag/data per way per set, valid/dirty bit-vectors per way, LRU per set
    logic [TAG_W-1:0]    tag_q   [2][NUM_SETS];
    logic [31:0]         data_q  [2][NUM_SETS][WORDS_PER_LINE];
    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] dirty_q [2];
    logic [NUM_SETS-1:0] lru_q;

    logic             victim_q, victim_d;
    logic [OFF_W-1:0] wcnt_q, wcnt_d;
    logic [LAT_W-1:0] lcnt_q, lcnt_d;

    // Datapath controls from the FSM
    logic access_c;    // access completes this cycle (hit or RESPOND)
    logic acc_way_c;   // way touched by the completing access
    logic hit_inc_c;
    logic miss_inc_c;
    logic fill_we_c;   // capture mem_din into the victim line
    logic fill_done_c; // last refill word: install tag, mark valid/clean

    // Address split
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_lsb;

    assign req_off         = req_addr[2 +: OFF_W];
    assign req_idx         = req_addr[2 + OFF_W +: IDX_W];
    assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsb = ^req_addr[1:0];

    // Tag compare and victim selection
    logic hit0, hit1, hit, victim_sel;

    assign hit0 = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1 = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit  = hit0 || hit1;

    always_comb begin
        if (!valid_q[0][req_idx])      victim_sel = 1'b0;
        else if (!valid_q[1][req_idx]) victim_sel = 1'b1;
        else                           victim_sel = lru_q[req_idx];
    end

    // State register and FSM-owned counters
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= LOOKUP;
            victim_q <= 1'b0;
            wcnt_q   <= '0;
            lcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            wcnt_q   <= wcnt_d;
            lcnt_q   <= lcnt_d;
        end
    end

    // Next state, memory interface and pipeline response
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        wcnt_d      = wcnt_q;
        lcnt_d      = lcnt_q;
        stall       = 1'b0;
        req_rdata   = '0;
        mem_csn     = 1'b1;
        mem_wen     = 1'b1;
        mem_addr    = '0;
        mem_be      = '0;
        mem_dout    = '0;
        access_c    = 1'b0;
        acc_way_c   = 1'b0;
        hit_inc_c   = 1'b0;
        miss_inc_c  = 1'b0;
        fill_we_c   = 1'b0;
        fill_done_c = 1'b0;

        case (state_q)
            LOOKUP: begin
                if (req_valid) begin
                    if (hit) begin
                        access_c  = 1'b1;
                        acc_way_c = hit1;
                        hit_inc_c = 1'b1;
                        if (!req_we) req_rdata = data_q[hit1][req_idx][req_off];
                    end else begin
                        stall      = 1'b1;
                        miss_inc_c = 1'b1;
                        victim_d   = victim_sel;
                        wcnt_d     = '0;
                        lcnt_d     = '0;
                        if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                            state_d = WRITEBACK;
                        else
                            state_d = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall    = 1'b1;
                mem_csn  = 1'b0;
                mem_wen  = 1'b0;
                mem_be   = 4'hF;
                mem_addr = {tag_q[victim_q][req_idx], req_idx, wcnt_q};
                mem_dout = data_q[victim_q][req_idx][wcnt_q];
                wcnt_d   = OFF_W'(wcnt_q + 1'b1);
                if (wcnt_q == WORD_LAST) state_d = REFILL;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_csn  = 1'b0;
                mem_addr = {req_tag, req_idx, wcnt_q};
                lcnt_d   = LAT_W'(lcnt_q + 1'b1);
                // Read data is valid on the last cycle the address is held
                if (lcnt_q == LAT_LAST) begin
                    lcnt_d    = '0;
                    fill_we_c = 1'b1;
                    wcnt_d    = OFF_W'(wcnt_q + 1'b1);
                    if (wcnt_q == WORD_LAST) begin
                        fill_done_c = 1'b1;
                        state_d     = RESPOND;
                    end
                end
            end
            RESPOND: begin
                access_c  = 1'b1;
                acc_way_c = victim_q;
                if (!req_we) req_rdata = data_q[victim_q][req_idx][req_off];
                state_d   = LOOKUP;
            end
            default: state_d = LOOKUP;
        endcase

        // Reset takes effect immediately on the bus so an aborted writeback emits nothing
        if (!RSTn) begin
            stall       = 1'b0;
            req_rdata   = '0;
            mem_csn     = 1'b1;
            mem_wen     = 1'b1;
            mem_addr    = '0;
            mem_be      = '0;
            mem_dout    = '0;
            access_c    = 1'b0;
            hit_inc_c   = 1'b0;
            miss_inc_c  = 1'b0;
            fill_we_c   = 1'b0;
            fill_done_c = 1'b0;
        end
    end

    // Line status, LRU and performance counters
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (access_c) begin
                lru_q[req_idx] <= ~acc_way_c;
                if (req_we) dirty_q[acc_way_c][req_idx] <= 1'b1;
            end
            if (fill_done_c) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= 1'b0;
            end
            if (hit_inc_c)  hit_count  <= hit_count + 32'd1;
            if (miss_inc_c) miss_count <= miss_count + 32'd1;
        end
    end

    // Tag and data arrays (no reset; qualified by valid)
    always_ff @(posedge CLK) begin
        if (access_c && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b])
                    data_q[acc_way_c][req_idx][req_off][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
        if (fill_we_c) data_q[victim_q][req_idx][wcnt_q] <= mem_din;
        if (fill_done_c) tag_q[victim_q][req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_dcache_sa2_wb.sv
// Directed self-checking bench for dcache_sa2_wb (default parameters).
// A small word-addressed memory model with one registered read stage
// logs every read/write cycle for comparison against hand-computed values.
module tb_dcache_sa2_wb;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req_valid;
    logic        req_we;
    logic [11:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_rdata;
    logic        stall;
    logic        mem_csn;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dcache_sa2_wb dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .req_rdata  (req_rdata),
        .stall      (stall),
        .mem_csn    (mem_csn),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Memory model and bus logs
    logic [31:0] mem [1024];
    logic [31:0] mem_rd_q = '0;
    bit          mem_ready = 1'b0;
    logic [9:0]  rd_log [$];
    logic [9:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [3:0]  wr_be_log [$];

    function automatic logic [31:0] pat(input int i);
        case (i)
            32'h010: pat = 32'h11111111;
            32'h011: pat = 32'h22222222;
            32'h012: pat = 32'h33333333;
            32'h013: pat = 32'h44444444;
            default: pat = 32'hA5000000 | 32'(i);
        endcase
    endfunction

    assign mem_din = mem_rd_q;

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else begin
            if (!mem_csn && !mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_dout[8*b +: 8];
                wr_addr_log.push_back(mem_addr);
                wr_data_log.push_back(mem_dout);
                wr_be_log.push_back(mem_be);
            end
            if (!mem_csn && mem_wen) rd_log.push_back(mem_addr);
            mem_rd_q <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One pipeline access held until stall drops; returns load data, stall cycles, csn at completion
    task automatic do_access(input logic we, input logic [11:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output int stalls, output logic csn);
        stalls = 0;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        #1;
        while (stall !== 1'b0 && stalls < 200) begin
            stalls++;
            @(negedge CLK);
            #1;
        end
        if (stalls >= 200) check_eq("stall_bound", 32'(stalls), 32'd0);
        rd  = req_rdata;
        csn = mem_csn;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    logic [31:0] rd;
    logic        csn;
    int          st;
    int          rb;
    int          wb;
    int          bad;
    logic [31:0] exp_wb [4];

    initial begin
        RSTn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        exp_wb[0] = 32'h11111111;
        exp_wb[1] = 32'h22222222;
        exp_wb[2] = 32'h333333AB;
        exp_wb[3] = 32'h44444444;

        // Reset values
        repeat (3) @(negedge CLK);
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_csn", 32'(mem_csn), 32'd1);
        check_eq("rst_wen", 32'(mem_wen), 32'd1);
        check_eq("rst_maddr", 32'(mem_addr), 32'd0);
        check_eq("rst_mbe", 32'(mem_be), 32'd0);
        check_eq("rst_mdout", mem_dout, 32'd0);
        check_eq("rst_rdata", req_rdata, 32'd0);
        check_eq("rst_hits", hit_count, 32'd0);
        check_eq("rst_misses", miss_count, 32'd0);
        RSTn = 1'b1;

        // Cold load miss: 1 + 4*2 stall cycles, each word read twice
        rb = rd_log.size();
        wb = wr_addr_log.size();
        do_access(1'b0, 12'h040, 4'h0, 32'h0, rd, st, csn);
        check_eq("miss1_stall", 32'(st), 32'd9);
        check_eq("miss1_rdata", rd, 32'h11111111);
        check_eq("miss1_misses", miss_count, 32'd1);
        check_eq("miss1_hits", hit_count, 32'd0);
        check_eq("miss1_nreads", 32'(rd_log.size() - rb), 32'd8);
        for (int k = 0; k < 8; k++)
            check_eq("miss1_raddr", 32'(rd_log[rb + k]), 32'h010 + 32'(k / 2));

        // Load hit in same line
        do_access(1'b0, 12'h044, 4'h0, 32'h0, rd, st, csn);
        check_eq("hit1_stall", 32'(st), 32'd0);
        check_eq("hit1_rdata", rd, 32'h22222222);
        check_eq("hit1_hits", hit_count, 32'd1);
        check_eq("hit1_csn", 32'(csn), 32'd1);

        // Store hit, byte 0 only, then read back
        do_access(1'b1, 12'h048, 4'b0001, 32'h000000AB, rd, st, csn);
        check_eq("st_stall", 32'(st), 32'd0);
        check_eq("st_hits", hit_count, 32'd2);
        do_access(1'b0, 12'h048, 4'h0, 32'h0, rd, st, csn);
        check_eq("st_rdback", rd, 32'h333333AB);
        check_eq("st_nowrites", 32'(wr_addr_log.size() - wb), 32'd0);

        // Same index, fills the empty way 1
        do_access(1'b0, 12'h140, 4'h0, 32'h0, rd, st, csn);
        check_eq("way1_stall", 32'(st), 32'd9);
        check_eq("way1_rdata", rd, 32'hA5000050);
        check_eq("way1_misses", miss_count, 32'd2);

        // Evicts dirty way 0 (LRU) with a 4-word writeback first
        wb = wr_addr_log.size();
        do_access(1'b0, 12'h240, 4'h0, 32'h0, rd, st, csn);
        check_eq("evict_stall", 32'(st), 32'd13);
        check_eq("evict_rdata", rd, 32'hA5000090);
        check_eq("evict_misses", miss_count, 32'd3);
        check_eq("evict_hits", hit_count, 32'd3);
        check_eq("evict_nwrites", 32'(wr_addr_log.size() - wb), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq("evict_waddr", 32'(wr_addr_log[wb + k]), 32'h010 + 32'(k));
            check_eq("evict_wdata", wr_data_log[wb + k], exp_wb[k]);
            check_eq("evict_wbe", 32'(wr_be_log[wb + k]), 32'hF);
        end

        // Reset in the middle of a refill
        wb = wr_addr_log.size();
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h040;
        repeat (5) @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check_eq("abort_stall_inrst", 32'(stall), 32'd0);
        RSTn      = 1'b1;
        req_valid = 1'b0;
        #1;
        check_eq("abort_stall", 32'(stall), 32'd0);
        check_eq("abort_hits", hit_count, 32'd0);
        check_eq("abort_misses", miss_count, 32'd0);
        check_eq("abort_nowrites", 32'(wr_addr_log.size() - wb), 32'd0);
        do_access(1'b0, 12'h040, 4'h0, 32'h0, rd, st, csn);
        check_eq("retry_stall", 32'(st), 32'd9);
        check_eq("retry_rdata", rd, 32'h11111111);
        check_eq("retry_misses", miss_count, 32'd1);

        // Idle cycles
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            #1;
            if (mem_csn !== 1'b1 || stall !== 1'b0) bad++;
        end
        check_eq("idle_bus", 32'(bad), 32'd0);
        check_eq("idle_hits", hit_count, 32'd0);
        check_eq("idle_misses", miss_count, 32'd1);

        // Store miss allocates into way 1, then merges the upper half-word
        do_access(1'b1, 12'h344, 4'b1100, 32'hDEAD0000, rd, st, csn);
        check_eq("stmiss_stall", 32'(st), 32'd9);
        check_eq("stmiss_misses", miss_count, 32'd2);
        do_access(1'b0, 12'h344, 4'h0, 32'h0, rd, st, csn);
        check_eq("stmiss_rdback", rd, 32'hDEAD00D1);
        check_eq("stmiss_hits", hit_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
